// File: rtl/demux_route_sequencer_if.sv
// rtl/demux_route_sequencer_if.sv - routing request handshake between a request source and the sequencer
interface demux_route_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_ch;
  logic [CNT_W-1:0] req_len;

  modport master (output req_valid, req_ch, req_len, input req_ready);
  modport slave  (input req_valid, req_ch, req_len, output req_ready);
endinterface

// File: rtl/demux_route_sequencer.sv
// rtl/demux_route_sequencer.sv - drives demux data/selects so y[ch] sees a clean pulse,
// moving selects only while i is low with guard cycles on both sides of the pulse
module demux_route_sequencer #(
  parameter int CNT_W     = 8,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_route_sequencer_if.slave  req,
  output logic                    i,
  output logic                    s2,
  output logic                    s1,
  output logic                    s0,
  output logic                    busy,
  output logic                    done
);
  localparam int SW  = $clog2(SETUP_CYC + 1);
  localparam int HW  = $clog2(HOLD_CYC + 1);
  localparam int CW0 = (CNT_W > SW) ? CNT_W : SW;
  localparam int CW  = (CW0 > HW) ? CW0 : HW;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [CNT_W-1:0] len_q, len_nx;
  logic [2:0]       sel, sel_nx;
  logic             i_nx, done_nx;
  logic             accept, last;

  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = req.req_valid && req.req_ready;
  assign last          = (cnt == CW'(1));
  assign {s2, s1, s0}  = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // One down-counter serves all timed states; it is reloaded on every state entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    len_nx   = len_q;
    sel_nx   = sel;
    i_nx     = i;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req.req_len != '0) begin
            state_nx = SETUP;
            sel_nx   = req.req_ch;
            cnt_nx   = CW'(SETUP_CYC);
            len_nx   = req.req_len;
          end else begin
            done_nx  = 1'b1;
          end
        end
      end
      SETUP: begin
        if (last) begin
          state_nx = ACTIVE;
          i_nx     = 1'b1;
          cnt_nx   = CW'(len_q);
        end else begin
          cnt_nx   = cnt - CW'(1);
        end
      end
      ACTIVE: begin
        if (last) begin
          state_nx = HOLD;
          i_nx     = 1'b0;
          cnt_nx   = CW'(HOLD_CYC);
        end else begin
          cnt_nx   = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (last) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx   = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      len_q <= '0;
      sel   <= 3'b000;
      i     <= 1'b0;
      done  <= 1'b0;
    end else begin
      cnt   <= cnt_nx;
      len_q <= len_nx;
      sel   <= sel_nx;
      i     <= i_nx;
      done  <= done_nx;
    end
  end
endmodule

// File: tb/tb_demux_route_sequencer.sv
// tb/tb_demux_route_sequencer.sv - directed and random requests checked cycle by cycle
// against a timeline model of each accepted request
module tb_demux_route_sequencer;
  localparam int CNT_W = 8;
  localparam int S     = 1;
  localparam int H     = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_route_sequencer_if #(.CNT_W(CNT_W)) req_if ();
  logic i, s2, s1, s0, busy, done;
  logic [7:0] y;

  demux_route_sequencer #(.CNT_W(CNT_W), .SETUP_CYC(S), .HOLD_CYC(H)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req_if.slave),
    .i    (i),
    .s2   (s2),
    .s1   (s1),
    .s0   (s0),
    .busy (busy),
    .done (done)
  );

  // Behavioural 1-to-8 demux attached to the sequencer outputs
  always_comb y = i ? (8'd1 << {s2, s1, s0}) : 8'd0;

  int errors = 0;
  int checks = 0;

  // Model: edge count n; interval n is the time after edge n
  int         n = 0;
  bit         has = 0;
  int         a = 0;
  int         m_len = 0;
  logic [2:0] m_ch = 3'd0;
  logic [2:0] exp_sel = 3'd0;
  int         next_acc = 0;
  bit         acc_flag = 0;
  logic [2:0] prev_sel = 3'd0;
  logic       prev_i = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    logic e_i, e_busy, e_done;
    logic [7:0] e_y;
    e_i    = has && m_len != 0 && n >= a + S && n < a + S + m_len;
    e_busy = has && m_len != 0 && n >= a && n < a + S + m_len + H;
    e_done = has && (n == ((m_len == 0) ? a : a + S + m_len + H));
    e_y    = e_i ? (8'd1 << exp_sel) : 8'd0;
    chk("i",     8'(i),              8'(e_i));
    chk("sel",   8'({s2, s1, s0}),   8'(exp_sel));
    chk("busy",  8'(busy),           8'(e_busy));
    chk("ready", 8'(req_if.req_ready), 8'(!e_busy));
    chk("done",  8'(done),           8'(e_done));
    chk("y",     y,                  e_y);
    if ({s2, s1, s0} !== prev_sel)
      chk("sel_change_guard", 8'({prev_i, i}), 8'd0);
    prev_sel = {s2, s1, s0};
    prev_i   = i;
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    acc_flag = 0;
    if (rst_n && req_if.req_valid && n >= next_acc) begin
      acc_flag = 1;
      a        = n;
      has      = 1;
      m_ch     = req_if.req_ch;
      m_len    = int'(req_if.req_len);
      if (m_len != 0) begin
        exp_sel  = m_ch;
        next_acc = n + S + m_len + H + 1;
      end else begin
        next_acc = n + 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic send(input logic [2:0] ch, input logic [7:0] len);
    req_if.req_valid = 1'b1;
    req_if.req_ch    = ch;
    req_if.req_len   = len;
    acc_flag = 0;
    for (int t = 0; t < 400 && !acc_flag; t++) step();
    if (!acc_flag) chk("accept_timeout", 8'(acc_flag), 8'd1);
    req_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && n < next_acc; t++) step();
    step();
  endtask

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_ch    = 3'd0;
    req_if.req_len   = 8'd0;
    #2;
    check_all();
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic pulse, then zero length keeping selects at 011
    send(3'd3, 8'd4);
    drain();
    send(3'd6, 8'd0);
    drain();

    // Back-to-back sweep with valid held high
    req_if.req_valid = 1'b1;
    req_if.req_len   = 8'd1;
    for (int k = 0; k < 8; k++) begin
      req_if.req_ch = 3'(k);
      acc_flag = 0;
      for (int t = 0; t < 20 && !acc_flag; t++) step();
      if (!acc_flag) chk("sweep_timeout", 8'(acc_flag), 8'd1);
    end
    req_if.req_valid = 1'b0;
    drain();

    // Request while busy
    send(3'd5, 8'd10);
    step();
    step();
    send(3'd2, 8'd3);
    drain();

    // Reset mid-pulse
    send(3'd5, 8'd10);
    step();
    step();
    step();
    #2;
    rst_n    = 1'b0;
    has      = 0;
    exp_sel  = 3'd0;
    next_acc = 0;
    prev_sel = 3'd0;
    prev_i   = 1'b0;
    #1;
    check_all();
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd1, 8'd2);
    drain();

    // Maximum length
    send(3'd7, 8'd255);
    drain();

    // Random requests, sometimes overlapping a busy sequencer
    for (int k = 0; k < 25; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 12)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
